// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the multicycle controller (master)
// and the instruction register / datapath / data memory side (slave).
interface multicycle_ctrl_if #(
   parameter int OPW   = 4,
   parameter int DEPTH = 15,
   parameter int SPW   = $clog2(DEPTH + 1)
);
   logic [OPW-1:0] opcode;
   logic           instr_valid;
   logic           zero;
   logic           mem_ready;

   logic           ir_wr;
   logic           pc_wr;
   logic           pc_src;
   logic           lwsw;
   logic           jump;
   logic           branch;
   logic           memread;
   logic           memwrt;
   logic           memtoreg;
   logic           regwrt;
   logic           regsrc;
   logic           push;
   logic           pop;
   logic [1:0]     wrtdata;
   logic [2:0]     ALUop;
   logic [SPW-1:0] stack_addr;
   logic [SPW-1:0] sp_count;
   logic           stack_full;
   logic           stack_empty;
   logic           illegal;
   logic           stack_fault;
   logic           busy;

   modport master (
      input  opcode, instr_valid, zero, mem_ready,
      output ir_wr, pc_wr, pc_src, lwsw, jump, branch, memread, memwrt,
             memtoreg, regwrt, regsrc, push, pop, wrtdata, ALUop,
             stack_addr, sp_count, stack_full, stack_empty, illegal,
             stack_fault, busy
   );

   modport slave (
      output opcode, instr_valid, zero, mem_ready,
      input  ir_wr, pc_wr, pc_src, lwsw, jump, branch, memread, memwrt,
             memtoreg, regwrt, regsrc, push, pop, wrtdata, ALUop,
             stack_addr, sp_count, stack_full, stack_empty, illegal,
             stack_fault, busy
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with hardware stack pointer.
// Define CTRL_STACK_GUARD_EN to enable the DECODE overflow/underflow guard.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_FETCH  | idle, waiting for instr_valid; latches opcode into op_q
// S_DECODE | legality and stack guard check
// S_EXEC   | ALU/shift/jump/branch complete here; address phase for mem ops
// S_MEM    | data memory access held until mem_ready
// S_WB     | register write-back for LW and POP
module multicycle_ctrl #(
   parameter int OPW   = 4,
   parameter int DEPTH = 15,
   parameter int SPW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

   state_t         state;
   state_t         state_nxt;
   logic [OPW-1:0] op_q;
   logic [SPW-1:0] sp_count;
   logic [SPW-1:0] sp_inc;
   logic [SPW-1:0] sp_dec;
   logic           sp_inc_en;
   logic           sp_dec_en;

   logic [3:0] op_lo;
   logic       hi_zero;
   logic       op_legal;
   logic       op_alu;
   logic       op_shift;
   logic       op_lw;
   logic       op_sw;
   logic       op_jump;
   logic       op_beq;
   logic       op_push;
   logic       op_pop;
   logic       sp_full;
   logic       sp_empty;
   logic       guard_trip;
   logic [2:0] alu_code;

   logic           c_ir_wr, c_pc_wr, c_pc_src, c_lwsw, c_jump, c_branch;
   logic           c_memread, c_memwrt, c_memtoreg, c_regwrt, c_regsrc;
   logic           c_push, c_pop, c_illegal, c_fault;
   logic [1:0]     c_wrtdata;
   logic [2:0]     c_aluop;
   logic [SPW-1:0] c_stack_addr;

   assign op_lo    = op_q[3:0];
   assign hi_zero  = ((op_q >> 4) == '0);
   assign op_legal = hi_zero && !(op_lo inside {4'b0111, 4'b1010, 4'b1011});
   assign op_alu   = hi_zero && (op_lo inside {4'b0000, 4'b0001, 4'b0010,
                                               4'b0011, 4'b0101, 4'b0110});
   assign op_shift = hi_zero && (op_lo == 4'b0100);
   assign op_lw    = hi_zero && (op_lo == 4'b1000);
   assign op_sw    = hi_zero && (op_lo == 4'b1001);
   assign op_jump  = hi_zero && (op_lo == 4'b1100);
   assign op_beq   = hi_zero && (op_lo == 4'b1101);
   assign op_push  = hi_zero && (op_lo == 4'b1110);
   assign op_pop   = hi_zero && (op_lo == 4'b1111);

   assign sp_full  = (sp_count == SP_MAX);
   assign sp_empty = (sp_count == '0);

   // Wrap in both directions; only reachable when the guard is compiled out.
   assign sp_inc = sp_full  ? '0     : sp_count + SPW'(1);
   assign sp_dec = sp_empty ? SP_MAX : sp_count - SPW'(1);

`ifdef CTRL_STACK_GUARD_EN
   assign guard_trip = (op_push && sp_full) || (op_pop && sp_empty);
`else
   assign guard_trip = 1'b0;
`endif

   always_comb begin
      alu_code = 3'b000;
      case (op_lo)
         4'b0001: alu_code = 3'b001;
         4'b0010: alu_code = 3'b100;
         4'b0011: alu_code = 3'b101;
         4'b0101: alu_code = 3'b010;
         4'b0110: alu_code = 3'b011;
         default: alu_code = 3'b000;
      endcase
   end

   assign sp_inc_en = (state == S_MEM) && bus.mem_ready && op_push;
   assign sp_dec_en = (state == S_WB) && op_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_FETCH;
         op_q     <= '0;
         sp_count <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && bus.instr_valid)
            op_q <= bus.opcode;
         if (sp_inc_en)
            sp_count <= sp_inc;
         else if (sp_dec_en)
            sp_count <= sp_dec;
      end
   end

   always_comb begin
      state_nxt    = state;
      c_ir_wr      = 1'b0;
      c_pc_wr      = 1'b0;
      c_pc_src     = 1'b0;
      c_lwsw       = 1'b0;
      c_jump       = 1'b0;
      c_branch     = 1'b0;
      c_memread    = 1'b0;
      c_memwrt     = 1'b0;
      c_memtoreg   = 1'b0;
      c_regwrt     = 1'b0;
      c_regsrc     = 1'b0;
      c_push       = 1'b0;
      c_pop        = 1'b0;
      c_illegal    = 1'b0;
      c_fault      = 1'b0;
      c_wrtdata    = 2'b00;
      c_aluop      = 3'b000;
      c_stack_addr = '0;

      case (state)
         S_FETCH: begin
            if (bus.instr_valid) begin
               c_ir_wr   = 1'b1;
               state_nxt = S_DECODE;
            end
         end

         S_DECODE: begin
            if (!op_legal) begin
               c_illegal = 1'b1;
               c_pc_wr   = 1'b1;
               state_nxt = S_FETCH;
            end else if (guard_trip) begin
               c_fault   = 1'b1;
               c_pc_wr   = 1'b1;
               state_nxt = S_FETCH;
            end else begin
               state_nxt = S_EXEC;
            end
         end

         S_EXEC: begin
            state_nxt = S_FETCH;
            if (op_alu || op_shift) begin
               c_regwrt = 1'b1;
               c_pc_wr  = 1'b1;
               c_aluop  = alu_code;
               if (op_shift) begin
                  c_wrtdata = 2'b01;
                  c_regsrc  = 1'b1;
               end
            end else if (op_jump) begin
               c_jump  = 1'b1;
               c_pc_wr = 1'b1;
            end else if (op_beq) begin
               c_branch = 1'b1;
               c_pc_src = bus.zero;
               c_aluop  = 3'b001;
               c_pc_wr  = 1'b1;
            end else if (op_lw || op_sw) begin
               c_lwsw    = op_lw;
               state_nxt = S_MEM;
            end else if (op_push || op_pop) begin
               c_regsrc  = 1'b1;
               state_nxt = S_MEM;
            end
         end

         S_MEM: begin
            if (op_lw) begin
               c_memread = 1'b1;
            end else if (op_sw) begin
               c_memwrt = 1'b1;
            end else if (op_push) begin
               c_memwrt     = 1'b1;
               c_push       = 1'b1;
               c_stack_addr = sp_count;
            end else if (op_pop) begin
               c_memread    = 1'b1;
               c_pop        = 1'b1;
               c_stack_addr = sp_count - SPW'(1);
            end
            if (bus.mem_ready) begin
               if (op_sw || op_push) begin
                  c_pc_wr   = 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end
         end

         S_WB: begin
            c_regwrt   = 1'b1;
            c_pc_wr    = 1'b1;
            c_memtoreg = op_lw;
            if (op_pop) begin
               c_wrtdata = 2'b10;
               c_regsrc  = 1'b1;
            end
            state_nxt = S_FETCH;
         end

         default: state_nxt = S_FETCH;
      endcase
   end

   assign bus.ir_wr       = c_ir_wr;
   assign bus.pc_wr       = c_pc_wr;
   assign bus.pc_src      = c_pc_src;
   assign bus.lwsw        = c_lwsw;
   assign bus.jump        = c_jump;
   assign bus.branch      = c_branch;
   assign bus.memread     = c_memread;
   assign bus.memwrt      = c_memwrt;
   assign bus.memtoreg    = c_memtoreg;
   assign bus.regwrt      = c_regwrt;
   assign bus.regsrc      = c_regsrc;
   assign bus.push        = c_push;
   assign bus.pop         = c_pop;
   assign bus.wrtdata     = c_wrtdata;
   assign bus.ALUop       = c_aluop;
   assign bus.stack_addr  = c_stack_addr;
   assign bus.sp_count    = sp_count;
   assign bus.stack_full  = sp_full;
   assign bus.stack_empty = sp_empty;
   assign bus.illegal     = c_illegal;
   assign bus.stack_fault = c_fault;
   assign bus.busy        = (state != S_FETCH);

endmodule
